// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SLL   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_NEZ   = 4'b0011;
    localparam logic [3:0] OP_GEU   = 4'b0100;
    localparam logic [3:0] OP_PASSB = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_OR    = 4'b0111;
    localparam logic [3:0] OP_XOR   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_LTS   = 4'b1011;
    localparam logic [3:0] OP_MUL   = 4'b1100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/mul_secuencial.sv
// Iterative shift-add multiplier datapath: one partial product per enabled cycle,
// WIDTH steps per operation, low WIDTH bits of the product only.
module mul_secuencial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] prod_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;

    // Product is exposed pre-register so the final step lands in the result on the same edge.
    assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod_o = acc_d;
    assign last_o = en_i && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (en_i) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_secuencial.sv
// Multi-cycle ALU: single-cycle ops register in one edge, multiply runs WIDTH
// edges in mul_secuencial; every accepted start yields exactly one done pulse.
module alu_secuencial
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             comp,
    output logic             cero
);

    alu_state_e       state_q;
    logic             busy_q, done_q, comp_q, cero_q;
    logic [WIDTH-1:0] result_q;

    logic [WIDTH-1:0]   res_d;
    logic               comp_d;
    logic [SHAMT_W-1:0] shamt;
    logic               mul_start, mul_en, mul_last;
    logic [WIDTH-1:0]   mul_prod;

    assign shamt = B[SHAMT_W-1:0];

    always_comb begin
        res_d  = '0;
        comp_d = 1'b0;
        case (control)
            OP_ADD:   res_d = A + B;
            OP_SLL:   res_d = A << shamt;
            OP_AND:   res_d = A & B;
            OP_NEZ:   comp_d = (A != '0);
            OP_GEU:   comp_d = (A >= B);
            OP_PASSB: res_d = B;
            OP_SUB:   res_d = A - B;
            OP_OR:    res_d = A | B;
            OP_XOR:   res_d = A ^ B;
            OP_SRL:   res_d = A >> shamt;
            OP_SRA:   res_d = WIDTH'($signed(A) >>> shamt);
            OP_LTS:   comp_d = ($signed(A) < $signed(B));
            default:  res_d = '0;
        endcase
        // Compares report through the low result bit so cero mirrors !comp.
        if (control == OP_NEZ || control == OP_GEU || control == OP_LTS)
            res_d = {{(WIDTH-1){1'b0}}, comp_d};
    end

    assign mul_start = (state_q == ST_IDLE) && start && (control == OP_MUL);
    assign mul_en    = (state_q == ST_MUL);

    mul_secuencial #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (mul_start),
        .en_i    (mul_en),
        .a_i     (A),
        .b_i     (B),
        .last_o  (mul_last),
        .prod_o  (mul_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            comp_q   <= 1'b0;
            cero_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (control == OP_MUL) begin
                            busy_q  <= 1'b1;
                            state_q <= ST_MUL;
                        end else begin
                            result_q <= res_d;
                            comp_q   <= comp_d;
                            cero_q   <= (res_d == '0);
                            done_q   <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_last) begin
                        result_q <= mul_prod;
                        comp_q   <= 1'b0;
                        cero_q   <= (mul_prod == '0);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign comp   = comp_q;
    assign cero   = cero_q;

endmodule

// File: tb/tb_alu_secuencial.sv
// Scoreboard bench for alu_secuencial: stimulus pushes expected responses,
// a negedge monitor pops and checks them (value and cycle) on every done.
module tb_alu_secuencial;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         comp;
        logic         cero;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   control = 4'b0000;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, comp, cero;
    logic [W-1:0] result;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];

    alu_secuencial #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .control (control),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .comp    (comp),
        .cero    (cero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("comp", W'(comp), W'(e.comp));
                chk("cero", W'(cero), W'(e.cero));
                chk("done_cycle", W'(cyc), W'(e.cyc));
            end
        end
    end

    // Drive a start at a negedge; returns at the following negedge with start still high.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic ec, input int lat);
        exp_t e;
        start = 1'b1; control = op; A = a; B = b;
        e.res = er; e.comp = ec; e.cero = (er == '0); e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic drop();
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_result", result, '0);
        chk("rst_comp", W'(comp), '0);
        chk("rst_cero", W'(cero), W'(1));
        rst_n = 1'b1;
        @(negedge clk);

        issue(4'b0000, 32'd3, 32'd4, 32'd7, 1'b0, 0);
        drop();
        chk("add_busy", W'(busy), '0);
        wait_drain();

        issue(4'b1100, 32'd7, 32'd6, 32'd42, 1'b0, W);
        drop();
        chk("mul_busy", W'(busy), W'(1));
        wait_drain();
        chk("mul_busy_end", W'(busy), '0);

        issue(4'b1100, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, W);
        control = 4'b0000; A = 32'd1; B = 32'd1;
        repeat (3) @(negedge clk);
        chk("ignored_start_busy", W'(busy), W'(1));
        drop();
        A = 32'd9; B = 32'd9;
        wait_drain();

        issue(4'b1010, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 0);
        issue(4'b1001, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 0);
        issue(4'b1011, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b1, 0);
        issue(4'b0100, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b1, 0);
        issue(4'b0110, 32'd5, 32'd5, 32'd0, 1'b0, 0);
        issue(4'b0001, 32'd1, 32'h0000_0021, 32'd2, 1'b0, 0);
        issue(4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 0);
        issue(4'b0011, 32'd0, 32'd7, 32'd0, 1'b0, 0);
        issue(4'b0101, 32'd3, 32'h0000_1234, 32'h0000_1234, 1'b0, 0);
        issue(4'b0111, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 0);
        issue(4'b1000, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1'b0, 0);
        issue(4'b0100, 32'd3, 32'd5, 32'd0, 1'b0, 0);
        issue(4'b1011, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
        drop();
        wait_drain();

        // Multiply aborted by reset: nothing pushed, so any done is flagged.
        start = 1'b1; control = 4'b1100; A = 32'd11; B = 32'd13;
        @(negedge clk);
        drop();
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", W'(busy), '0);
        chk("abort_result", result, '0);
        chk("abort_cero", W'(cero), W'(1));
        chk("abort_comp", W'(comp), '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        issue(4'b1100, 32'd2, 32'd3, 32'd6, 1'b0, W);
        drop();
        wait_drain();

        issue(4'b1111, 32'd3, 32'd4, 32'd0, 1'b0, 0);
        drop();
        wait_drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_secuencial.md
Name: alu_secuencial

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Keeps the existing 3-bit operation encodings and adds subtraction, OR/XOR, right shifts, signed compare and an iterative shift-add multiply.
- All results are registered and returned through a start/busy/done handshake, so the control unit can stall on long operations.
- Sits between the register-file read stage and the write-back mux.

Parameters:
- WIDTH, 32, operand/result width in bits (power of 2, >= 8).
- SHAMT_W, $clog2(WIDTH), number of low B bits used as shift amount.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request an operation; sampled only when busy=0.
- control  input  4  operation select (encodings below).
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B / shift amount.
- busy  output  1  multiply in progress; start ignored.
- done  output  1  one-cycle pulse: result/comp/cero valid and updated.
- result  output  WIDTH  registered result, held until next accepted start.
- comp  output  1  registered comparison outcome.
- cero  output  1  registered, 1 when result==0.

Behaviour:
- Reset: async on rst_n low. busy=0, done=0, result=0, comp=0, cero=1, FSM=IDLE, counter=0. Reset mid-multiply aborts it and produces no done.
- Opcodes:
  - 0000 A+B
  - 0001 A<<shamt
  - 0010 A&B
  - 0011 comp=(A!=0)
  - 0100 comp=(A>=B) unsigned
  - 0101 pass B
  - 0110 A-B
  - 0111 A|B
  - 1000 A^B
  - 1001 A>>shamt logical
  - 1010 A>>>shamt arithmetic
  - 1011 comp=(A<B) signed
  - 1100 A*B, low WIDTH bits
  - 1101-1111 undefined.
- shamt = B[SHAMT_W-1:0]; upper B bits are ignored. Add, sub and mul wrap modulo 2^WIDTH; no overflow flag.
- Compare ops (0011, 0100, 1011): result={WIDTH-1 zeros, comp}, so cero=!comp. All other ops: comp=0.
- Undefined opcode: result=0, comp=0, cero=1, done still pulses.
- FSM states: IDLE, MUL.
  - IDLE: start=1 at edge N with a single-cycle op -> result/comp/cero loaded at edge N, done=1 during cycle N..N+1, stay IDLE.
  - IDLE: start=1 with op 1100 -> latch A, B; acc=0; cnt=0; busy=1 from edge N; go MUL.
  - MUL: one shift-add step per edge (if mplier[0], acc+=mcand; mcand<<=1; mplier>>=1; cnt++). At the edge where cnt reaches WIDTH: load result, done=1, busy=0, go IDLE.
  - Multiply latency: done high after edge N+WIDTH (32 cycles at default).
- done is high for exactly one cycle per accepted start; otherwise 0.
- start while busy=1 is ignored; operands are not re-latched.
- Back-to-back: a start sampled on the same edge that asserts done is not possible in MUL (busy=1 before that edge). In IDLE, consecutive starts each produce a done on the following cycle.
- Operand or control changes after acceptance have no effect on an in-flight multiply.

Decomposition:
- Package alu_pkg holds the 4-bit opcode localparams (OP_ADD, OP_SLL, OP_AND, OP_NEZ, OP_GEU, OP_PASSB, OP_SUB, OP_OR, OP_XOR, OP_SRL, OP_SRA, OP_LTS, OP_MUL) and the FSM state encoding.
- One sub-module: mul_secuencial (WIDTH-parameterised shift-add multiplier with start/done), instantiated by alu_secuencial. All single-cycle ops stay in the top module's combinational block feeding the output registers.

Test Plan:
- Reset, then A=3, B=4, control=0000, start pulse -> next cycle done=1, result=7, cero=0, busy stays 0.
- A=7, B=6, control=1100, start -> busy=1 for 32 cycles, done pulses once at edge N+32, result=42.
- A=0xFFFFFFFF, B=2, control=1100 -> result=0xFFFFFFFE (wrap). During busy, start with control=0000 -> ignored, no extra done.
- A=0x80000000, B=0x00000024 (shamt=4), control=1010 -> result=0xF8000000. Same operands with control=1001 -> 0x08000000.
- A=0xFFFFFFFE (-2), B=1, control=1011 -> comp=1, result=1, cero=0. Same operands with control=0100 -> comp=1. A=5, B=5, control=0110 -> result=0, cero=1.
- Start multiply, assert rst_n=0 at cycle 10 -> outputs immediately reset values, no done ever. After release, A=2, B=3, control=1100 -> result=6 after 32 cycles. Also control=1111 -> done=1, result=0, cero=1.
